// File: rtl/uart_tx_if.sv
// Write-side interface of the UART transmitter: byte strobe and data in,
// FIFO status out.
interface uart_tx_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic [DEPTH_LOG2:0]   fifo_count;

  // Producer side: drives bytes, watches FIFO status.
  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  fifo_count
  );

  // Transmitter side: accepts bytes, reports FIFO status.
  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 (or 8E1) serial framer.
// Back-to-back frames are sent without an idle gap while the FIFO has data.
module uart_tx #(
  parameter int DIVISOR    = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave wr_if,
  output logic     busy,
  output logic     txd
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam int                CW        = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);
  localparam logic [15:0]       BAUD_LAST = 16'(DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             baud_q, baud_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shift_q, shift_d;
  logic                    txd_q, txd_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, full_d;
  logic [7:0]              fifo_mem [DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  // Acceptance uses the registered full flag, so a same-edge pop never frees room.
  assign push    = wr_if.wr_en && !full_q;
  assign bit_end = (baud_q == BAUD_LAST);

  // Framer next-state: bit timing, state sequencing and FIFO pop decisions.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the bit that begins after this edge, registered so txd never glitches.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_idx_d];
      PARITY:  txd_d = ^shift_d;
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; a simultaneous push and pop cancel out.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_CNT);
  end

  // State registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_if.wr_data;
    end
  end

  assign wr_if.full       = full_q;
  assign wr_if.fifo_count = count_q;
  assign busy             = (state_q != IDLE);
  assign txd              = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a no-parity and an even-parity instance (DIVISOR=4),
// a queue/countdown reference model, and per-instance serial-line monitors
// that decode frames and check them against a scoreboard of accepted bytes.
module tb_uart_tx;

  localparam int DIV    = 4;
  localparam int DL2    = 3;
  localparam int DEPTH  = 1 << DL2;
  localparam int FRAME0 = 10 * DIV;
  localparam int FRAME1 = 11 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DEPTH_LOG2(DL2)) if0 ();
  uart_tx_if #(.DEPTH_LOG2(DL2)) if1 ();
  logic busy0, txd0, busy1, txd1;

  uart_tx #(.DIVISOR(DIV), .PARITY_EN(1'b0), .DEPTH_LOG2(DL2)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .wr_if (if0),
    .busy  (busy0),
    .txd   (txd0)
  );

  uart_tx #(.DIVISOR(DIV), .PARITY_EN(1'b1), .DEPTH_LOG2(DL2)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .wr_if (if1),
    .busy  (busy1),
    .txd   (txd1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: FIFO contents, remaining frame cycles, byte on the line.
  logic [7:0] mq0[$], mq1[$];
  logic [7:0] exp0[$], exp1[$];
  int         starts0[$];
  int         rem[2];
  logic [7:0] cur[2];
  logic       last_par1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int frame_len(input int w);
    return (w == 0) ? FRAME0 : FRAME1;
  endfunction

  function automatic logic line(input int w);
    return (w == 0) ? txd0 : txd1;
  endfunction

  // Expected line level from frame position: start, 8 data LSB first, [parity], stop.
  function automatic logic exp_txd(input int w);
    int         p;
    int         b;
    logic [7:0] c;
    if (rem[w] == 0) return 1'b1;
    p = frame_len(w) - rem[w];
    b = p / DIV;
    c = cur[w];
    if (b == 0) return 1'b0;
    if (b <= 8) return c[b-1];
    if (w == 1 && b == 9) return ^c;
    return 1'b1;
  endfunction

  // One clock edge of the model for one instance.
  task automatic model_one(input int w, input logic en, input logic [7:0] d);
    int sz;
    sz = (w == 0) ? mq0.size() : mq1.size();
    if (rem[w] > 0) rem[w]--;
    if (rem[w] == 0 && sz > 0) begin
      if (w == 0) cur[w] = mq0.pop_front();
      else        cur[w] = mq1.pop_front();
      rem[w] = frame_len(w);
    end
    if (en && sz != DEPTH) begin
      if (w == 0) begin mq0.push_back(d); exp0.push_back(d); end
      else        begin mq1.push_back(d); exp1.push_back(d); end
    end
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    exp0.delete(); exp1.delete();
    rem[0] = 0; rem[1] = 0;
  endtask

  // Drive one cycle of writes, advance the model, compare visible state.
  task automatic step(input logic en0, input logic [7:0] d0,
                      input logic en1, input logic [7:0] d1);
    @(negedge clk);
    if0.wr_en = en0; if0.wr_data = d0;
    if1.wr_en = en1; if1.wr_data = d1;
    @(posedge clk);
    model_one(0, en0, d0);
    model_one(1, en1, d1);
    #1;
    check("count0", int'(if0.fifo_count), mq0.size());
    check("full0",  int'(if0.full),       int'(mq0.size() == DEPTH));
    check("busy0",  int'(busy0),          int'(rem[0] > 0));
    check("txd0",   int'(txd0),           int'(exp_txd(0)));
    check("count1", int'(if1.fifo_count), mq1.size());
    check("full1",  int'(if1.full),       int'(mq1.size() == DEPTH));
    check("busy1",  int'(busy1),          int'(rem[1] > 0));
    check("txd1",   int'(txd1),           int'(exp_txd(1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (rem[0] == 0 && rem[1] == 0 && mq0.size() == 0 && mq1.size() == 0) break;
      step(1'b0, 8'h00, 1'b0, 8'h00);
    end
    idle(4);
    check("drained0", exp0.size(), 0);
    check("drained1", exp1.size(), 0);
  endtask

  // Serial-line monitor: decodes each frame and checks it against the scoreboard.
  task automatic monitor(input int w);
    int         flen;
    int         bad;
    logic       s [FRAME1];
    logic [7:0] got;
    logic [7:0] want;
    logic       aborted;
    flen = frame_len(w);
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || line(w) !== 1'b0) continue;
      if (w == 0) starts0.push_back(cyc);
      s[0]    = 1'b0;
      aborted = 1'b0;
      for (int i = 1; i < flen; i++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        s[i] = line(w);
      end
      if (aborted) continue;
      bad = 0;
      for (int i = 0; i < flen; i++) if (s[i] !== s[(i / DIV) * DIV]) bad++;
      for (int b = 0; b < 8; b++) got[b] = s[(b + 1) * DIV];
      check($sformatf("mon%0d_bit_width", w), bad, 0);
      check($sformatf("mon%0d_stop", w), int'(s[flen-1]), 1);
      if ((w == 0 && exp0.size() == 0) || (w == 1 && exp1.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mon%0d_unexpected_frame: decoded 0x%02h with nothing expected at cycle %0d",
                 w, got, cyc);
      end else begin
        want = (w == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("mon%0d_data", w), int'(got), int'(want));
        if (w == 1) begin
          last_par1 = s[9 * DIV];
          check("mon1_parity", int'(s[9 * DIV]), int'(^want));
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int maxc;
    logic       e0, e1;
    logic [7:0] r0, r1;

    if0.wr_en = 1'b0; if0.wr_data = 8'h00;
    if1.wr_en = 1'b0; if1.wr_data = 8'h00;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd0",   int'(txd0), 1);
    check("rst_busy0",  int'(busy0), 0);
    check("rst_full0",  int'(if0.full), 0);
    check("rst_count0", int'(if0.fifo_count), 0);
    check("rst_txd1",   int'(txd1), 1);
    check("rst_busy1",  int'(busy1), 0);
    check("rst_full1",  int'(if1.full), 0);
    check("rst_count1", int'(if1.fifo_count), 0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Single byte into an idle block.
    step(1'b1, 8'h55, 1'b0, 8'h00);
    check("single_count_write", int'(if0.fifo_count), 1);
    check("single_txd_write",   int'(txd0), 1);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00);
      if (i == 0) begin
        check("single_txd_fall",  int'(txd0), 0);
        check("single_count_pop", int'(if0.fifo_count), 0);
      end
      if (busy0) bc++;
    end
    check("single_busy_len", bc, FRAME0);

    // Back-to-back frames with no idle gap.
    starts0.delete();
    maxc = 0;
    step(1'b1, 8'hA5, 1'b0, 8'h00);
    if (int'(if0.fifo_count) > maxc) maxc = int'(if0.fifo_count);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    if (int'(if0.fifo_count) > maxc) maxc = int'(if0.fifo_count);
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    if (int'(if0.fifo_count) > maxc) maxc = int'(if0.fifo_count);
    idle(3 * FRAME0 + 10);
    check("b2b_peak_count", maxc, 2);
    check("b2b_frames", starts0.size(), 3);
    if (starts0.size() == 3) begin
      check("b2b_gap1", starts0[1] - starts0[0], FRAME0);
      check("b2b_gap2", starts0[2] - starts0[1], FRAME0);
    end
    check("b2b_drained", exp0.size(), 0);

    // Overflow, then a write colliding with the end-of-stop pop.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 8'h00);
      if (i == 1) check("ovf_first_popped", int'(busy0), 1);
      if (i == 8) check("ovf_full_after_9th", int'(if0.full), 1);
    end
    check("ovf_count_after_10th", int'(if0.fifo_count), DEPTH);
    for (int i = 0; i < FRAME0 && rem[0] != 1; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
    check("collide_pre_full", int'(if0.full), 1);
    step(1'b1, 8'hC1, 1'b0, 8'h00);
    check("collide_drop_count", int'(if0.fifo_count), DEPTH - 1);
    step(1'b1, 8'hC2, 1'b0, 8'h00);
    check("collide_next_count", int'(if0.fifo_count), DEPTH);
    drain();

    // Even parity on the second instance.
    last_par1 = 1'b0;
    step(1'b0, 8'h00, 1'b1, 8'h07);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00);
      if (busy1) bc++;
    end
    check("par07_frame_len", bc, FRAME1);
    check("par07_bit", int'(last_par1), 1);
    last_par1 = 1'b1;
    step(1'b0, 8'h00, 1'b1, 8'h03);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, 1'b0, 8'h00);
      if (busy1) bc++;
    end
    check("par03_frame_len", bc, FRAME1);
    check("par03_bit", int'(last_par1), 0);

    // Randomized traffic on both instances, enough to hit full.
    for (int i = 0; i < 900; i++) begin
      e0 = ($urandom_range(0, 11) == 0);
      e1 = ($urandom_range(0, 11) == 0);
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      step(e0, r0, e1, r1);
    end
    drain();

    // Reset in the middle of DATA bit 3 with two bytes queued.
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b1, 8'h11, 1'b0, 8'h00);
    step(1'b1, 8'h22, 1'b0, 8'h00);
    for (int i = 0; i < FRAME0 && (rem[0] == 0 || FRAME0 - rem[0] < 4 * DIV + 1); i++)
      step(1'b0, 8'h00, 1'b0, 8'h00);
    check("mid_rst_queued", int'(if0.fifo_count), 2);
    check("mid_rst_in_bit3", int'(txd0), 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_txd",   int'(txd0), 1);
    check("mid_rst_busy",  int'(busy0), 0);
    check("mid_rst_count", int'(if0.fifo_count), 0);
    check("mid_rst_full",  int'(if0.full), 0);
    model_reset();
    starts0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2 * FRAME0);
    check("mid_rst_no_frames", starts0.size(), 0);
    check("mid_rst_scoreboard", exp0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIVISOR, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
REQ-003 SHALL have parameter DEPTH_LOG2, default 3: the FIFO holds 2^DEPTH_LOG2 bytes.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  byte write strobe, sampled at the rising edge.
REQ-007 wr_data  input  8  byte to transmit, qualified by wr_en.
REQ-008 full  output  1  FIFO count equals depth; registered.
REQ-009 fifo_count  output  DEPTH_LOG2+1  bytes held in the FIFO; excludes the byte currently being shifted.
REQ-010 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-011 txd  output  1  serial line; idle level 1; registered, no combinational path from any input.

Function
REQ-012 SHALL accept a write on an edge with wr_en=1 and full=0.
- A write with full=1 is dropped and leaves the FIFO unchanged.
- The full value sampled at that edge decides acceptance, even if a pop occurs on the same edge.
REQ-013 SHALL be a first-in-first-out store; read and write pointers wrap modulo depth.
REQ-014 SHALL keep fifo_count unchanged when an accepted write and a pop occur on the same edge.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE:
- txd=1.
- If fifo_count>0 at an edge: pop the head byte into the shift register, go to START, and drive txd=0.
REQ-017 A byte written into an empty FIFO with the FSM in IDLE SHALL be popped on the next edge; txd falls one edge after the write edge.
REQ-018 Every bit (START, each DATA bit, PARITY, STOP) SHALL last exactly DIVISOR cycles, timed by a baud counter reloaded at each bit boundary.
REQ-019 START SHALL drive txd=0, then go to DATA.
REQ-020 DATA SHALL send 8 bits LSB first, using a 3-bit index.
- After bit 7: go to PARITY if PARITY_EN=1, else STOP.
REQ-021 PARITY SHALL drive the XOR of the 8 data bits (even parity), then go to STOP.
REQ-022 STOP SHALL drive txd=1 for DIVISOR cycles.
- At the end of STOP: if fifo_count>0, pop the next byte and go directly to START on the same edge (no idle gap).
- Otherwise go to IDLE.
REQ-023 Frame length SHALL be 10*DIVISOR cycles (PARITY_EN=0) or 11*DIVISOR cycles (PARITY_EN=1).
REQ-024 Writes during a frame SHALL NOT disturb the byte being shifted.
REQ-025 A byte SHALL leave the FIFO only by a pop in IDLE or at the end of STOP.

Reset
REQ-026 While reset=1, and asynchronously on its assertion, the block SHALL force:
- txd=1, busy=0, full=0, fifo_count=0;
- FSM=IDLE;
- FIFO pointers, baud counter and bit index to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (txd returns to 1) and discard all FIFO contents.
REQ-028 After reset deasserts, the first rising edge SHALL behave as IDLE with an empty FIFO.

Verification
REQ-029 The bench SHALL cover these directed scenarios (DIVISOR=4 unless stated):
- Single byte: write 0x55 into an idle block -> txd=0 one edge later; line reads 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; busy high for exactly 40 cycles; fifo_count returns to 0 on the pop edge.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles -> three frames with no idle cycles between stop and start; decoded bytes arrive in order; fifo_count peaks at 2.
- Overflow (DEPTH_LOG2=3): write 10 bytes 0x00..0x09 on consecutive cycles starting from idle -> first byte popped immediately; full asserts after the 9th write; the 10th write (0x09) is dropped; 0x00..0x08 are transmitted.
- Parity (PARITY_EN=1): send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 44 cycles.
- Simultaneous pop and write: with full=1, assert wr_en on the edge where STOP ends and pops -> that write is dropped, fifo_count goes from 8 to 7; a write on the next edge is accepted, fifo_count returns to 8.
- Mid-frame reset: assert reset during DATA bit 3 of 0x00 with 2 bytes queued -> txd=1, busy=0, fifo_count=0 immediately; no further frames after release.
